// File: rtl/vip_frame_ctrl_if.sv
// Bus bundle between the frame controller and its source RAM, the core's
// input/output FIFOs and the result RAM.
interface vip_frame_ctrl_if #(
  parameter int DWIDTH         = 32,
  parameter int NUM_CHANNEL_IN = 8,
  parameter int AW             = 12
) ();
  logic [AW-1:0]                    src_addr;
  logic                             src_rden;
  logic [NUM_CHANNEL_IN*DWIDTH-1:0] src_rdata;
  logic [NUM_CHANNEL_IN*DWIDTH-1:0] fifo_in_data;
  logic                             fifo_in_wrreq;
  logic                             fifo_in_full;
  logic [DWIDTH:0]                  fifo_out_data;
  logic                             fifo_out_rdreq;
  logic                             fifo_out_empty;
  logic [AW-1:0]                    dst_addr;
  logic                             dst_wren;
  logic [DWIDTH:0]                  dst_wdata;

  modport master (
    output src_addr, src_rden, fifo_in_data, fifo_in_wrreq,
           fifo_out_rdreq, dst_addr, dst_wren, dst_wdata,
    input  src_rdata, fifo_in_full, fifo_out_data, fifo_out_empty
  );

  modport slave (
    input  src_addr, src_rden, fifo_in_data, fifo_in_wrreq,
           fifo_out_rdreq, dst_addr, dst_wren, dst_wdata,
    output src_rdata, fifo_in_full, fifo_out_data, fifo_out_empty
  );
endinterface

// File: rtl/vip_frame_ctrl.sv
// Frame controller: streams one frame from source RAM into the core's input
// FIFO while concurrently draining core results into the result RAM.
module vip_frame_ctrl #(
  parameter int DWIDTH         = 32,
  parameter int NUM_CHANNEL_IN = 8,
  parameter int WIDTH          = 56,
  parameter int HEIGHT         = 56,
  parameter int OUT_COUNT      = WIDTH*HEIGHT,
  parameter int AW             = 12
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  vip_frame_ctrl_if.master bus
);

  localparam int         PIX   = WIDTH*HEIGHT;
  localparam logic [AW:0] PIX_C = PIX[AW:0];
  localparam logic [AW:0] OUT_C = OUT_COUNT[AW:0];
  localparam logic [AW:0] ONE   = 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW:0]   rd_cnt, feed_cnt, req_cnt, drain_cnt;
  logic [AW-1:0] src_addr_q;
  logic          rden_q, wrreq_q, rdreq_q, wren_q;
  logic          feed_last, drain_last;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Look ahead by the write in flight so done follows the last write by one cycle.
  always_comb begin
    state_nxt  = state;
    feed_last  = (feed_cnt + (wrreq_q ? ONE : '0)) == PIX_C;
    drain_last = (drain_cnt + (wren_q ? ONE : '0)) == OUT_C;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (feed_last && drain_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_cnt     <= '0;
      feed_cnt   <= '0;
      req_cnt    <= '0;
      drain_cnt  <= '0;
      src_addr_q <= '0;
      rden_q     <= 1'b0;
      wrreq_q    <= 1'b0;
      rdreq_q    <= 1'b0;
      wren_q     <= 1'b0;
    end else begin
      rden_q  <= 1'b0;
      rdreq_q <= 1'b0;
      wrreq_q <= rden_q;
      wren_q  <= rdreq_q;
      if (state == IDLE) begin
        rd_cnt    <= '0;
        feed_cnt  <= '0;
        req_cnt   <= '0;
        drain_cnt <= '0;
      end else begin
        if (state == RUN && !bus.fifo_in_full && rd_cnt < PIX_C) begin
          rden_q     <= 1'b1;
          src_addr_q <= rd_cnt[AW-1:0];
          rd_cnt     <= rd_cnt + ONE;
        end
        if (wrreq_q) feed_cnt <= feed_cnt + ONE;
        if (state == RUN && !bus.fifo_out_empty && req_cnt < OUT_C) begin
          rdreq_q <= 1'b1;
          req_cnt <= req_cnt + ONE;
        end
        if (wren_q) drain_cnt <= drain_cnt + ONE;
      end
    end
  end

  // RAM and FIFO read data already lag their strobes by one cycle, so the
  // delayed write strobes line up with them without another data register.
  assign bus.src_addr       = src_addr_q;
  assign bus.src_rden       = rden_q;
  assign bus.fifo_in_wrreq  = wrreq_q;
  assign bus.fifo_in_data   = wrreq_q ? bus.src_rdata : '0;
  assign bus.fifo_out_rdreq = rdreq_q;
  assign bus.dst_wren       = wren_q;
  assign bus.dst_addr       = drain_cnt[AW-1:0];
  assign bus.dst_wdata      = wren_q ? bus.fifo_out_data : '0;
  assign busy               = (state == RUN);
  assign done               = (state == DONE);

endmodule

// File: tb/tb_vip_frame_ctrl.sv
// Self-checking bench for vip_frame_ctrl on a 4x4 frame with RAM/FIFO models.
module tb_vip_frame_ctrl;
  localparam int DW = 32, NC = 8, W = 4, H = 4, N = W*H, OUTC = 16, AW = 5;
  localparam int VW = NC*DW;

  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic busy, done;

  vip_frame_ctrl_if #(.DWIDTH(DW), .NUM_CHANNEL_IN(NC), .AW(AW)) bus ();
  vip_frame_ctrl #(.DWIDTH(DW), .NUM_CHANNEL_IN(NC), .WIDTH(W), .HEIGHT(H),
                   .OUT_COUNT(OUTC), .AW(AW))
    dut (.clock(clock), .reset(reset), .start(start), .busy(busy), .done(done), .bus(bus));

  always #5 clock = ~clock;

  int total = 0, bad = 0;
  logic [VW-1:0] mem [32];
  logic [DW:0]   res [32];
  logic [4:0]    res_idx;
  bit full_force = 0, full_rand = 0, empty_force = 0, empty_rand = 0;
  bit rnd_full = 0, rnd_empty = 0, full_at_edge = 0, empty_at_edge = 0;

  // Source RAM and output FIFO: read data valid the cycle after the strobe.
  always @(posedge clock) begin
    full_at_edge  <= bus.fifo_in_full;
    empty_at_edge <= bus.fifo_out_empty;
    if (bus.src_rden) bus.src_rdata <= mem[bus.src_addr];
    if (bus.fifo_out_rdreq) begin
      bus.fifo_out_data <= res[res_idx];
      res_idx <= res_idx + 5'd1;
    end
    if (reset || (start && !busy)) res_idx <= '0;
  end

  always @(negedge clock) begin
    rnd_full  = ($urandom_range(0, 3) == 0);
    rnd_empty = ($urandom_range(0, 2) == 0);
  end
  assign bus.fifo_in_full   = full_force  | (full_rand  & rnd_full);
  assign bus.fifo_out_empty = empty_force | (empty_rand & rnd_empty);

  // Transaction log, restarted whenever busy rises.
  int cyc = 0;
  int rd_addr_q[$], rd_cyc_q[$], wr_cyc_q[$], dst_addr_q[$], dst_cyc_q[$], done_cyc_q[$];
  logic [VW-1:0] wr_data_q[$];
  logic [DW:0]   dst_data_q[$];
  int strobe_idle = 0, viol_full = 0, viol_empty = 0, done_busy = 0;
  bit busy_d = 0;

  always @(negedge clock) begin
    cyc++;
    if (busy && !busy_d) begin
      rd_addr_q.delete(); rd_cyc_q.delete(); wr_cyc_q.delete(); wr_data_q.delete();
      dst_addr_q.delete(); dst_cyc_q.delete(); dst_data_q.delete(); done_cyc_q.delete();
      strobe_idle = 0; viol_full = 0; viol_empty = 0; done_busy = 0;
    end
    if (bus.src_rden) begin
      rd_addr_q.push_back(int'(bus.src_addr)); rd_cyc_q.push_back(cyc);
      if (full_at_edge) viol_full++;
    end
    if (bus.fifo_in_wrreq) begin wr_data_q.push_back(bus.fifo_in_data); wr_cyc_q.push_back(cyc); end
    if (bus.fifo_out_rdreq && empty_at_edge) viol_empty++;
    if (bus.dst_wren) begin
      dst_addr_q.push_back(int'(bus.dst_addr)); dst_data_q.push_back(bus.dst_wdata);
      dst_cyc_q.push_back(cyc);
    end
    if (!busy && (bus.src_rden || bus.fifo_in_wrreq || bus.fifo_out_rdreq || bus.dst_wren))
      strobe_idle++;
    if (done) begin
      done_cyc_q.push_back(cyc);
      if (busy || !busy_d) done_busy++;
    end
    busy_d = busy;
  end

  task automatic pulse_start();
    start = 1'b1; @(negedge clock); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done) begin ok = 1; break; end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++)
      for (int c = 0; c < NC; c++) mem[i][c*DW +: DW] = $urandom();
    for (int i = 0; i < OUTC; i++) res[i] = {1'($urandom_range(0, 1)), 32'($urandom())};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got %b want 0", done); end
    total++; if ({bus.src_rden, bus.fifo_in_wrreq, bus.fifo_out_rdreq, bus.dst_wren} !== 4'b0) begin
      bad++; $display("FAIL rst_strobes got %b want 0000",
                      {bus.src_rden, bus.fifo_in_wrreq, bus.fifo_out_rdreq, bus.dst_wren});
    end
    total++; if (bus.src_addr !== '0 || bus.dst_addr !== '0) begin
      bad++; $display("FAIL rst_addr got %0d/%0d want 0/0", bus.src_addr, bus.dst_addr);
    end
    total++; if (bus.fifo_in_data !== '0 || bus.dst_wdata !== '0) begin
      bad++; $display("FAIL rst_data got %h/%h want 0", bus.fifo_in_data, bus.dst_wdata);
    end
    reset = 1'b0;
    repeat (6) @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_no_start busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    bit ok;
    for (int i = 0; i < N; i++)
      for (int c = 0; c < NC; c++) mem[i][c*DW +: DW] = 32'(i*16 + c);
    for (int i = 0; i < OUTC; i++) res[i] = 33'h1_0000_0000 + 33'(i);
    pulse_start();
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout got no done want done"); end
    @(negedge clock);
    total++; if (rd_addr_q.size() != N || wr_data_q.size() != N || dst_addr_q.size() != OUTC) begin
      bad++; $display("FAIL basic_counts got rd=%0d wr=%0d dst=%0d want %0d/%0d/%0d",
                      rd_addr_q.size(), wr_data_q.size(), dst_addr_q.size(), N, N, OUTC);
    end else begin
      for (int i = 0; i < N; i++) begin
        total++;
        if (rd_addr_q[i] != i || rd_cyc_q[i] != rd_cyc_q[0] + i || wr_cyc_q[i] != rd_cyc_q[i] + 1
            || wr_data_q[i] !== mem[i]) begin
          bad++; $display("FAIL basic_feed[%0d] got addr=%0d cyc=%0d wcyc=%0d data=%h want addr=%0d cyc=%0d wcyc=%0d data=%h",
                          i, rd_addr_q[i], rd_cyc_q[i], wr_cyc_q[i], wr_data_q[i],
                          i, rd_cyc_q[0] + i, rd_cyc_q[i] + 1, mem[i]);
        end
      end
      for (int i = 0; i < OUTC; i++) begin
        total++;
        if (dst_addr_q[i] != i || dst_data_q[i] !== res[i]) begin
          bad++; $display("FAIL basic_drain[%0d] got %0d:%h want %0d:%h",
                          i, dst_addr_q[i], dst_data_q[i], i, res[i]);
        end
      end
      total++;
      if (done_cyc_q.size() != 1 || done_cyc_q[0] != dst_cyc_q[OUTC-1] + 1) begin
        bad++; $display("FAIL basic_done_timing got n=%0d cyc=%0d want n=1 cyc=%0d",
                        done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1,
                        dst_cyc_q[OUTC-1] + 1);
      end
    end
    total++; if (done_busy != 0) begin bad++; $display("FAIL basic_busy_at_done got %0d want 0", done_busy); end
    total++; if (strobe_idle != 0) begin bad++; $display("FAIL basic_idle_strobe got %0d want 0", strobe_idle); end
  endtask

  task automatic test_full_stall();
    bit ok;
    int n = 0, extra = 0;
    fill_random();
    pulse_start();
    for (int i = 0; i < 100 && n < 5; i++) begin
      @(negedge clock);
      if (bus.src_rden) n++;
    end
    full_force = 1;
    total++; if (n != 5) begin bad++; $display("FAIL stall_reach5 got %0d want 5", n); end
    repeat (10) begin
      @(negedge clock);
      if (bus.src_rden) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL stall_rden_held got %0d want 0", extra); end
    total++; if (rd_addr_q.size() != 5 || wr_data_q.size() != 5) begin
      bad++; $display("FAIL stall_counts got rd=%0d wr=%0d want 5/5", rd_addr_q.size(), wr_data_q.size());
    end
    full_force = 0;
    @(negedge clock);
    total++; if (bus.src_rden !== 1'b1 || bus.src_addr !== 5'd5) begin
      bad++; $display("FAIL stall_resume got rden=%b addr=%0d want 1/5", bus.src_rden, bus.src_addr);
    end
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_timeout got no done want done"); end
    @(negedge clock);
    total++; if (wr_data_q.size() != N) begin
      bad++; $display("FAIL stall_total_wr got %0d want %0d", wr_data_q.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        total++;
        if (rd_addr_q[i] != i || wr_data_q[i] !== mem[i]) begin
          bad++; $display("FAIL stall_feed[%0d] got %0d:%h want %0d:%h", i, rd_addr_q[i], wr_data_q[i], i, mem[i]);
        end
      end
    end
    total++; if (viol_full != 0) begin bad++; $display("FAIL stall_read_while_full got %0d want 0", viol_full); end
  endtask

  task automatic test_drain_stall();
    bit ok;
    int nw = 0, nd = 0;
    fill_random();
    empty_force = 1;
    pulse_start();
    for (int i = 0; i < 100 && nw < N; i++) begin
      @(negedge clock);
      if (bus.fifo_in_wrreq) nw++;
      if (bus.dst_wren) nd++;
    end
    total++; if (nw != N || nd != 0 || busy !== 1'b1) begin
      bad++; $display("FAIL drain_stall got wr=%0d wren=%0d busy=%b want %0d/0/1", nw, nd, busy, N);
    end
    empty_force = 0;
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL drain_timeout got no done want done"); end
    @(negedge clock);
    total++; if (dst_addr_q.size() != OUTC) begin
      bad++; $display("FAIL drain_count got %0d want %0d", dst_addr_q.size(), OUTC);
    end else begin
      for (int i = 0; i < OUTC; i++) begin
        total++;
        if (dst_addr_q[i] != i || dst_data_q[i] !== res[i]) begin
          bad++; $display("FAIL drain_data[%0d] got %0d:%h want %0d:%h", i, dst_addr_q[i], dst_data_q[i], i, res[i]);
        end
      end
      total++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != dst_cyc_q[OUTC-1] + 1) begin
        bad++; $display("FAIL drain_done_timing got n=%0d want 1 at %0d", done_cyc_q.size(), dst_cyc_q[OUTC-1] + 1);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int last;
    for (int f = 0; f < 4; f++) begin
      fill_random();
      full_rand  = (f % 2 == 0);
      empty_rand = (f >= 1);
      pulse_start();
      wait_done(1000, ok);
      total++; if (!ok) begin bad++; $display("FAIL rand%0d_timeout got no done want done", f); end
      @(negedge clock);
      total++;
      if (rd_addr_q.size() != N || wr_data_q.size() != N || dst_addr_q.size() != OUTC) begin
        bad++; $display("FAIL rand%0d_counts got %0d/%0d/%0d want %0d/%0d/%0d", f,
                        rd_addr_q.size(), wr_data_q.size(), dst_addr_q.size(), N, N, OUTC);
        continue;
      end
      for (int i = 0; i < N; i++) begin
        total++;
        if (rd_addr_q[i] != i || wr_data_q[i] !== mem[i] || wr_cyc_q[i] != rd_cyc_q[i] + 1) begin
          bad++; $display("FAIL rand%0d_feed[%0d] got %0d:%h want %0d:%h", f, i, rd_addr_q[i], wr_data_q[i], i, mem[i]);
        end
      end
      for (int i = 0; i < OUTC; i++) begin
        total++;
        if (dst_addr_q[i] != i || dst_data_q[i] !== res[i]) begin
          bad++; $display("FAIL rand%0d_drain[%0d] got %0d:%h want %0d:%h", f, i, dst_addr_q[i], dst_data_q[i], i, res[i]);
        end
      end
      last = (wr_cyc_q[N-1] > dst_cyc_q[OUTC-1]) ? wr_cyc_q[N-1] : dst_cyc_q[OUTC-1];
      total++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != last + 1) begin
        bad++; $display("FAIL rand%0d_done got n=%0d cyc=%0d want n=1 cyc=%0d", f, done_cyc_q.size(),
                        (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, last + 1);
      end
      total++; if (viol_full != 0 || viol_empty != 0 || strobe_idle != 0 || done_busy != 0) begin
        bad++; $display("FAIL rand%0d_rules got full=%0d empty=%0d idle=%0d busy=%0d want 0", f,
                        viol_full, viol_empty, strobe_idle, done_busy);
      end
    end
    full_rand = 0; empty_rand = 0;
  endtask

  task automatic test_restart();
    bit ok;
    fill_random();
    pulse_start();
    repeat (4) @(negedge clock);
    pulse_start();
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL restart_timeout got no done want done"); end
    @(negedge clock);
    total++; if (rd_addr_q.size() != N || dst_addr_q.size() != OUTC || done_cyc_q.size() != 1) begin
      bad++; $display("FAIL restart_ignored got rd=%0d dst=%0d done=%0d want %0d/%0d/1",
                      rd_addr_q.size(), dst_addr_q.size(), done_cyc_q.size(), N, OUTC);
    end
    pulse_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL restart_accept busy got %b want 1", busy); end
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL restart2_timeout got no done want done"); end
    @(negedge clock);
    total++; if (rd_addr_q.size() != N || rd_addr_q[0] != 0 || wr_data_q.size() != N || wr_data_q[0] !== mem[0]) begin
      bad++; $display("FAIL restart2_frame got rd=%0d first=%0d want %0d/0", rd_addr_q.size(),
                      (rd_addr_q.size() > 0) ? rd_addr_q[0] : -1, N);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n = 0, dn, si;
    fill_random();
    pulse_start();
    for (int i = 0; i < 100 && n < 7; i++) begin
      @(negedge clock);
      if (bus.src_rden) n++;
    end
    total++; if (n != 7) begin bad++; $display("FAIL rmid_reach7 got %0d want 7", n); end
    reset = 1'b1;
    @(negedge clock);
    total++; if ({bus.src_rden, bus.fifo_in_wrreq, bus.fifo_out_rdreq, bus.dst_wren, busy, done} !== 6'b0) begin
      bad++; $display("FAIL rmid_abort got %b want 000000",
                      {bus.src_rden, bus.fifo_in_wrreq, bus.fifo_out_rdreq, bus.dst_wren, busy, done});
    end
    dn = done_cyc_q.size();
    si = strobe_idle;
    reset = 1'b0;
    repeat (20) @(negedge clock);
    total++; if (done_cyc_q.size() != dn || strobe_idle != si || busy !== 1'b0) begin
      bad++; $display("FAIL rmid_quiet got done=%0d strobes=%0d busy=%b want %0d/%0d/0",
                      done_cyc_q.size(), strobe_idle, busy, dn, si);
    end
    pulse_start();
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_newframe_timeout got no done want done"); end
    @(negedge clock);
    total++; if (rd_addr_q.size() != N || rd_addr_q[0] != 0 || dst_data_q.size() != OUTC || dst_data_q[0] !== res[0]) begin
      bad++; $display("FAIL rmid_newframe got rd=%0d dst=%0d want %0d/%0d", rd_addr_q.size(), dst_data_q.size(), N, OUTC);
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_basic();
    test_full_stall();
    test_drain_stall();
    test_random();
    test_restart();
    test_reset_mid();
    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
